// File: rtl/output_layer_mac.sv
// -----------------------------------------------------------------------------
// output_layer_mac
//
// Output-layer compute stage of the digit-recognition network. It walks the
// output-weight ROM and the hidden-unit result RAM, forms NUM_OUTPUT signed
// dot products of NUM_HIDDEN terms each, and reports the index and score of
// the largest one with a one-cycle done pulse.
//
// Ports
//   clk       in   system clock, all logic on the rising edge
//   rst       in   synchronous, active-high reset
//   start     in   begin one classification (sampled only while idle)
//   wt_addr   out  weight ROM address = o*NUM_HIDDEN + h
//   wt_data   in   weight ROM data, signed, valid one cycle after wt_addr
//   hid_addr  out  hidden RAM read address = h
//   hid_data  in   hidden value, unsigned, valid one cycle after hid_addr
//   busy      out  high from the cycle after start is accepted through DONE
//   done      out  one-cycle pulse when digit/score are updated
//   digit     out  index of the winning output unit
//   score     out  signed accumulator value of the winner
// -----------------------------------------------------------------------------
module output_layer_mac #(
   parameter int NUM_HIDDEN = 32,
   parameter int NUM_OUTPUT = 10,
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 22
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              start,
   output logic [$clog2(NUM_OUTPUT)+$clog2(NUM_HIDDEN)-1:0] wt_addr,
   input  logic [DATA_WIDTH-1:0]                             wt_data,
   output logic [$clog2(NUM_HIDDEN)-1:0]                     hid_addr,
   input  logic [DATA_WIDTH-1:0]                             hid_data,
   output logic                                              busy,
   output logic                                              done,
   output logic [$clog2(NUM_OUTPUT)-1:0]                     digit,
   output logic [ACC_WIDTH-1:0]                              score
);

   localparam int HID_W  = $clog2(NUM_HIDDEN);
   localparam int OUT_W  = $clog2(NUM_OUTPUT);
   localparam int PROD_W = 2 * DATA_WIDTH + 1;

   localparam logic [HID_W-1:0] H_LAST = HID_W'(NUM_HIDDEN - 1);
   localparam logic [HID_W-1:0] H_ONE  = HID_W'(1);
   localparam logic [OUT_W-1:0] O_LAST = OUT_W'(NUM_OUTPUT - 1);
   localparam logic [OUT_W-1:0] O_ONE  = OUT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_DRAIN,
      S_CMP,
      S_DONE
   } state_t;

   state_t                       r_state;
   state_t                       w_next;

   logic [OUT_W-1:0]             r_o;
   logic [HID_W-1:0]             r_h;
   logic                         r_rd_vld;
   logic signed [ACC_WIDTH-1:0]  r_acc;
   logic signed [ACC_WIDTH-1:0]  r_best;
   logic [OUT_W-1:0]             r_best_idx;
   logic [OUT_W-1:0]             r_digit;
   logic signed [ACC_WIDTH-1:0]  r_score;

   logic signed [PROD_W-1:0]     w_prod;
   logic signed [ACC_WIDTH-1:0]  w_prod_ext;
   logic                         w_take;

   // The hidden value is unsigned, so a zero sign bit is prepended before the
   // signed multiply; the 17-bit product is then sign-extended to the
   // accumulator width.
   assign w_prod     = $signed({1'b0, hid_data}) * $signed(wt_data);
   assign w_prod_ext = {{(ACC_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};

   // Strict greater-than keeps the lower index on ties; unit 0 always loads.
   assign w_take = (r_o == '0) || (r_acc > r_best);

   // NUM_HIDDEN is a power of two, so o*NUM_HIDDEN + h is a plain concat.
   // Both counters come straight from registers, so the ROM address never
   // mixes a new row with an old column during ACCUM.
   assign wt_addr  = {r_o, r_h};
   assign hid_addr = r_h;

   assign busy  = (r_state != S_IDLE);
   assign done  = (r_state == S_DONE);
   assign digit = r_digit;
   assign score = r_score;

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      // NOTE: the default assignment first guarantees w_next is written on
      // every path, so no latch is inferred.
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_ACCUM;
         S_ACCUM: if (r_h == H_LAST) w_next = S_DRAIN;
         S_DRAIN: w_next = S_CMP;
         S_CMP:   w_next = (r_o == O_LAST) ? S_DONE : S_ACCUM;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: counters, accumulator, running best and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_o        <= '0;
         r_h        <= '0;
         r_rd_vld   <= 1'b0;
         r_acc      <= '0;
         r_best     <= '0;
         r_best_idx <= '0;
         r_digit    <= '0;
         r_score    <= '0;
      end else begin
         // Memory data arrives one cycle after each ACCUM address.
         r_rd_vld <= (r_state == S_ACCUM);

         if (r_rd_vld) r_acc <= r_acc + w_prod_ext;

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_o   <= '0;
                  r_h   <= '0;
                  r_acc <= '0;
               end
            end
            S_ACCUM: begin
               r_h <= r_h + H_ONE;
            end
            S_CMP: begin
               if (w_take) begin
                  r_best     <= r_acc;
                  r_best_idx <= r_o;
               end
               r_acc <= '0;
               r_h   <= '0;
               if (r_o == O_LAST) begin
                  // Results are loaded on the edge into DONE, so the final
                  // unit's compare has to be folded in here directly.
                  r_digit <= w_take ? r_o   : r_best_idx;
                  r_score <= w_take ? r_acc : r_best;
               end else begin
                  r_o <= r_o + O_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/output_layer_mac.md
Name: output_layer_mac

Overview:
- Output-layer compute stage of the digit-recognition network. Sits directly downstream of the output-weight ROM and the hidden-unit result RAM, and consumes both.
- Sequences both memories and computes 10 output-unit dot products, each over 32 hidden units, with signed multiply-accumulate.
- Selects the winning output (argmax) and reports the recognised digit with a one-cycle done pulse.

Parameters:
- NUM_HIDDEN, 32, hidden units per output dot product (power of 2).
- NUM_OUTPUT, 10, number of output units / digit classes.
- DATA_WIDTH, 8, width of hidden values and weights.
- ACC_WIDTH, 22, signed accumulator width.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin one classification; sampled only in IDLE.
- wt_addr  output  9  weight ROM address = o*NUM_HIDDEN + h.
- wt_data  input  8  weight ROM q, signed two's complement, valid 1 cycle after wt_addr.
- hid_addr  output  5  hidden RAM read address = h.
- hid_data  input  8  hidden value, unsigned, valid 1 cycle after hid_addr.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse when digit/score are updated.
- digit  output  4  index of the winning output unit.
- score  output  22  signed accumulator value of the winner.

Behaviour:
- Reset values: busy=0, done=0, digit=0, score=0. Counters o and h, the accumulator, best and rd_vld are all cleared. State is IDLE.
- Reset has priority over all other inputs, including when asserted mid-operation: the block returns to IDLE, no done pulse is generated, and digit/score reset to 0.
- States: IDLE, ACCUM, DRAIN, CMP, DONE.
- IDLE:
  - If start=1, clear o, h and acc, then go to ACCUM.
  - Otherwise stay in IDLE.
  - start is ignored in every other state.
- ACCUM:
  - wt_addr and hid_addr are driven combinationally from the registered o and h counters.
  - h increments each cycle. When h=NUM_HIDDEN-1, go to DRAIN.
  - ACCUM therefore lasts exactly 32 cycles.
- Read latency:
  - rd_vld is a register set on every ACCUM cycle, so it is high in the cycle after each ACCUM cycle.
  - When rd_vld=1: acc <= acc + $signed({1'b0,hid_data}) * $signed(wt_data).
  - The product is 17-bit signed, sign-extended to ACC_WIDTH.
  - With 22 bits the accumulator cannot overflow: worst-case magnitude is 32*255*128 = 1044480.
- DRAIN: one cycle that accumulates the product for h=31, then go to CMP.
- CMP:
  - If o==0, or acc > best (strict signed compare), load best <= acc and best_idx <= o.
  - Then clear acc and h.
  - If o==NUM_OUTPUT-1, go to DONE. Otherwise o <= o+1 and go to ACCUM.
  - Ties keep the lower index.
- DONE:
  - digit <= best_idx and score <= best are registered on entry.
  - done=1 for exactly this one cycle, then go to IDLE.
- Latency:
  - Each output unit takes 34 cycles.
  - If start is sampled at edge E0, done is high in the cycle after edge E340, i.e. 341 edges after E0.
  - busy is high for 341 cycles.
- Address outputs are don't-care outside ACCUM but must remain in range (wt_addr < 320). The ROM must never see a stale address from another row during ACCUM.
- digit and score hold their last values until the next DONE or reset.

Test Plan:
- All weights 0, hidden values arbitrary, pulse start -> done one cycle at E0+341, digit=0, score=0 (tie resolves to lowest index).
- Row 7 weights all +1, other rows 0, all hidden values 255 -> digit=7, score=8160; wt_addr sweeps 224..255 during the 8th ACCUM window.
- All weights -128 (0x80), hidden values 255 -> every score = -1044480, digit=0. Checks sign extension and accumulator width.
- Rows 4 and 8 weights +2, others +1, hidden values 0..31 (h) -> rows 4 and 8 tie at 992, digit=4, score=992. Checks the strict-greater tie rule.
- Assert start again at E0+50 while busy -> ignored, single done at E0+341 with an unchanged result.
- Assert rst at E0+100 -> busy=0, done=0, digit=0. A fresh start afterwards completes correctly in 341 cycles.
